// File: rtl/fcvt_pkg.sv
// fcvt_pkg: shared types and constants for the FP-to-integer converter.
//   - rm_e          : RISC-V rounding modes (5..7 are treated as RTZ by users)
//   - FF_*          : bit positions inside the 5-bit fflags vector {NV,DZ,OF,UF,NX}
//   - exp_w/man_w/bias : binary32 / binary64 format geometry from FP_W
//   - sat_*         : saturation patterns for 32/64-bit results
//   - s12_t / s23_t : stage registers S1->S2 and S2->S3. They are sized for the
//                     widest configuration (binary64 -> 64-bit); narrower
//                     configurations use the low bits only.
package fcvt_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  localparam int FF_NV = 4;
  localparam int FF_DZ = 3;
  localparam int FF_OF = 2;
  localparam int FF_UF = 1;
  localparam int FF_NX = 0;

  localparam int MAX_EXP_W = 12;  // binary64 exponent width + 1 (signed)
  localparam int MAX_SIG_W = 53;  // binary64 significand incl. hidden bit
  localparam int MAX_MAG_W = 65;  // INT_W + 1 for a 64-bit result

  function automatic int exp_w(input int fp_w);
    return (fp_w == 32) ? 8 : 11;
  endfunction

  function automatic int man_w(input int fp_w);
    return (fp_w == 32) ? 23 : 52;
  endfunction

  function automatic int bias(input int fp_w);
    return (fp_w == 32) ? 127 : 1023;
  endfunction

  localparam logic [63:0] SMAX_32 = 64'h0000_0000_7FFF_FFFF;
  localparam logic [63:0] SMIN_32 = 64'h0000_0000_8000_0000;
  localparam logic [63:0] UMAX_32 = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] SMAX_64 = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SMIN_64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] UMAX_64 = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [63:0] sat_smax(input int int_w);
    return (int_w == 32) ? SMAX_32 : SMAX_64;
  endfunction

  function automatic logic [63:0] sat_smin(input int int_w);
    return (int_w == 32) ? SMIN_32 : SMIN_64;
  endfunction

  function automatic logic [63:0] sat_umax(input int int_w);
    return (int_w == 32) ? UMAX_32 : UMAX_64;
  endfunction

  typedef struct packed {
    logic                 sign;
    logic [MAX_EXP_W-1:0] exp;   // unbiased exponent, two's complement
    logic [MAX_SIG_W-1:0] sig;   // significand with hidden bit
    logic                 is_zero;
    logic                 is_inf;
    logic                 is_nan;
    logic                 is_signed;
    logic [2:0]           rm;
  } s12_t;

  typedef struct packed {
    logic                 sign;
    logic [MAX_MAG_W-1:0] mag;   // truncated integer magnitude
    logic                 g;
    logic                 s;
    logic                 too_large;
    logic                 is_inf;
    logic                 is_nan;
    logic                 is_signed;
    logic [2:0]           rm;
  } s23_t;

endpackage

// File: rtl/fcvt_fp2int_pipe_if.sv
// fcvt_fp2int_pipe_if: operand and result channels of the FP-to-int converter.
// Params: FP_W (operand width), INT_W (result width), TAG_W (opaque tag width).
// Modports: master = FPU issue/writeback side, slave = converter.
//
// Handshake: a channel transfers on every rising clk edge where valid and
// ready are both high. A producer holding valid high keeps its payload
// stable until the transfer; valid never depends combinationally on ready.
// ready may depend on the receiver's state (in_ready follows out_ready).
interface fcvt_fp2int_pipe_if #(
  parameter int FP_W  = 64,
  parameter int INT_W = 64,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [FP_W-1:0]  in_fp;
  logic             in_signed;
  logic [2:0]       in_rm;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [INT_W-1:0] out_int;
  logic [TAG_W-1:0] out_tag;
  logic [4:0]       out_fflags;

  modport master (
    output in_valid, in_fp, in_signed, in_rm, in_tag, out_ready,
    input  in_ready, out_valid, out_int, out_tag, out_fflags
  );

  modport slave (
    input  in_valid, in_fp, in_signed, in_rm, in_tag, out_ready,
    output in_ready, out_valid, out_int, out_tag, out_fflags
  );
endinterface

// File: rtl/fcvt_round.sv
// fcvt_round: combinational rounding-increment decision.
// Inputs: rm (3-bit rounding mode, 5..7 act as RTZ), sign, lsb, g (guard),
// s (sticky). Output: inc = 1 when the truncated magnitude must be bumped.
module fcvt_round
  import fcvt_pkg::*;
(
  input  logic [2:0] rm,
  input  logic       sign,
  input  logic       lsb,
  input  logic       g,
  input  logic       s,
  output logic       inc
);
  always_comb begin
    inc = 1'b0;
    case (rm)
      RM_RNE:  inc = g & (s | lsb);
      RM_RDN:  inc = sign & (g | s);
      RM_RUP:  inc = ~sign & (g | s);
      RM_RMM:  inc = g;
      default: inc = 1'b0;
    endcase
  end
endmodule

// File: rtl/fcvt_fp2int_pipe.sv
// fcvt_fp2int_pipe: 3-stage binary32/binary64 -> signed/unsigned 32/64-bit
// integer converter with RISC-V rounding and saturation.
// Ports: clk, rst (async, active-high), bus (fcvt_fp2int_pipe_if.slave).
// Stages: S1 unpack/classify, S2 align, S3 round/range-check/negate.
// All stage registers advance together on en = ~out_valid | out_ready.
// Build option: define FCVT_FP2INT_FLAGS_EN to compute NV/NX on out_fflags;
// otherwise out_fflags is tied to zero and no flag register exists.
module fcvt_fp2int_pipe
  import fcvt_pkg::*;
#(
  parameter int FP_W  = 64,
  parameter int INT_W = 64,
  parameter int TAG_W = 5
) (
  input logic             clk,
  input logic             rst,
  fcvt_fp2int_pipe_if.slave bus
);
  localparam int EW    = exp_w(FP_W);
  localparam int MW    = man_w(FP_W);
  localparam int BIAS  = bias(FP_W);
  localparam int SIG_W = MW + 1;
  localparam int MAG_W = INT_W + 1;
  localparam int FXW   = MAG_W + SIG_W;  // INT_W+1 integer bits, SIG_W fraction bits

  localparam logic [INT_W-1:0]     SMAX    = INT_W'(sat_smax(INT_W));
  localparam logic [INT_W-1:0]     SMIN    = INT_W'(sat_smin(INT_W));
  localparam logic [INT_W-1:0]     UMAX    = INT_W'(sat_umax(INT_W));
  localparam logic [MAX_EXP_W-1:0] EXP_M1  = '1;
  localparam logic [MAX_EXP_W-1:0] EXP_TOP = MAX_EXP_W'(INT_W);

  logic en;
  assign en = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = en;

  // ---------------- S1: unpack and classify ----------------
  logic [EW-1:0]    bexp;
  logic [MW-1:0]    frac;
  logic signed [EW:0] unb_exp;
  s12_t             s1_d, s12_q;
  logic             v1;
  logic [TAG_W-1:0] tag1;

  always_comb begin
    bexp = bus.in_fp[FP_W-2 -: EW];
    frac = bus.in_fp[MW-1:0];
    // Subnormals use the minimum normal exponent with a zero hidden bit.
    unb_exp = $signed({1'b0, (bexp == '0) ? EW'(1) : bexp}) - $signed((EW+1)'(BIAS));
    s1_d           = '0;
    s1_d.sign      = bus.in_fp[FP_W-1];
    s1_d.exp       = MAX_EXP_W'(unb_exp);
    s1_d.sig       = MAX_SIG_W'({bexp != '0, frac});
    s1_d.is_zero   = (bexp == '0) && (frac == '0);
    s1_d.is_inf    = (bexp == '1) && (frac == '0);
    s1_d.is_nan    = (bexp == '1) && (frac != '0);
    s1_d.is_signed = bus.in_signed;
    s1_d.rm        = bus.in_rm;
  end

  // ---------------- S2: align ----------------
  logic signed [MAX_EXP_W-1:0] e2;
  logic [MAX_EXP_W-1:0]        shamt;
  logic [FXW-1:0]              fx;
  logic                        tiny, too_large;
  s23_t                        s2_d, s23_q;
  logic                        v2;
  logic [TAG_W-1:0]            tag2;

  always_comb begin
    e2        = $signed(s12_q.exp);
    // Shift 0 puts the binary point just above the significand (exp = -1).
    shamt     = s12_q.exp + MAX_EXP_W'(1);
    fx        = FXW'(s12_q.sig[SIG_W-1:0]) << shamt;
    tiny      = e2 < $signed(EXP_M1);
    too_large = e2 > $signed(EXP_TOP);
    s2_d           = '0;
    s2_d.sign      = s12_q.sign;
    s2_d.too_large = too_large;
    s2_d.is_inf    = s12_q.is_inf;
    s2_d.is_nan    = s12_q.is_nan;
    s2_d.is_signed = s12_q.is_signed;
    s2_d.rm        = s12_q.rm;
    if (tiny) begin
      s2_d.s = ~s12_q.is_zero;
    end else if (!too_large) begin
      s2_d.mag = MAX_MAG_W'(fx[FXW-1:SIG_W]);
      s2_d.g   = fx[SIG_W-1];
      s2_d.s   = |fx[SIG_W-2:0];
    end
  end

  // ---------------- S3: round, range-check, negate ----------------
  logic [MAG_W-1:0] mag3;
  logic [MAG_W:0]   rmag;    // one extra bit for the rounding carry
  logic             inc, neg, fits, special;
  logic [INT_W-1:0] res;

  fcvt_round u_round (
    .rm   (s23_q.rm),
    .sign (s23_q.sign),
    .lsb  (mag3[0]),
    .g    (s23_q.g),
    .s    (s23_q.s),
    .inc  (inc)
  );

  always_comb begin
    mag3 = s23_q.mag[MAG_W-1:0];
    rmag = {1'b0, mag3} + {{MAG_W{1'b0}}, inc};
    neg  = s23_q.sign;
    if (s23_q.is_signed) begin
      // Positive limit 2^(INT_W-1)-1; negative limit exactly 2^(INT_W-1).
      fits = (rmag[MAG_W:INT_W-1] == 3'b000) ||
             (neg && rmag[MAG_W:INT_W-1] == 3'b001 && rmag[INT_W-2:0] == '0);
    end else begin
      fits = neg ? (rmag == '0) : (rmag[MAG_W:INT_W] == 2'b00);
    end
    special = s23_q.is_nan | s23_q.is_inf | s23_q.too_large | ~fits;
    if (special) begin
      // NaN saturates like +inf regardless of its sign bit.
      if (neg && !s23_q.is_nan) res = s23_q.is_signed ? SMIN : '0;
      else                      res = s23_q.is_signed ? SMAX : UMAX;
    end else if (s23_q.is_signed && neg) begin
      res = {INT_W{1'b0}} - rmag[INT_W-1:0];
    end else begin
      res = rmag[INT_W-1:0];
    end
  end

  // ---------------- stage registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1            <= 1'b0;
      v2            <= 1'b0;
      bus.out_valid <= 1'b0;
      s12_q         <= '0;
      s23_q         <= '0;
      tag1          <= '0;
      tag2          <= '0;
      bus.out_int   <= '0;
      bus.out_tag   <= '0;
    end else if (en) begin
      v1            <= bus.in_valid;
      s12_q         <= s1_d;
      tag1          <= bus.in_tag;
      v2            <= v1;
      s23_q         <= s2_d;
      tag2          <= tag1;
      bus.out_valid <= v2;
      bus.out_int   <= res;
      bus.out_tag   <= tag2;
    end
  end

`ifdef FCVT_FP2INT_FLAGS_EN
  logic [4:0] fflags_d;

  always_comb begin
    fflags_d        = '0;
    fflags_d[FF_NV] = special;
    fflags_d[FF_DZ] = 1'b0;
    fflags_d[FF_OF] = 1'b0;
    fflags_d[FF_UF] = 1'b0;
    fflags_d[FF_NX] = ~special & (s23_q.g | s23_q.s);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     bus.out_fflags <= '0;
    else if (en) bus.out_fflags <= fflags_d;
  end
`else
  assign bus.out_fflags = 5'b0;
`endif

endmodule
